// File: rtl/sr_flop_pkg.sv
// Shared definitions for the SR-flop register family.
//   SR_* constants : action taken by a bit when s=r=1.
//   op_e           : operation class selected for a cycle; also usable by datapath control.
//   op_select()    : priority decode clr > ld > inr > per-bit s/r, gated by en.
package sr_flop_pkg;

  localparam int unsigned SR_HOLD     = 0;
  localparam int unsigned SR_SET_WINS = 1;
  localparam int unsigned SR_RST_WINS = 2;
  localparam int unsigned SR_TOGGLE   = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_LD,
    OP_INR,
    OP_SR
  } op_e;

  function automatic op_e op_select(input logic en, input logic clr, input logic ld,
                                    input logic inr);
    op_e op;
    if (!en) begin
      op = OP_NONE;
    end else if (clr) begin
      op = OP_CLR;
    end else if (ld) begin
      op = OP_LD;
    end else if (inr) begin
      op = OP_INR;
    end else begin
      op = OP_SR;
    end
    return op;
  endfunction

endpackage

// File: rtl/sr_flop_reg_if.sv
// Control/data bundle for sr_flop_reg.
//   master : controller side, drives en/clr/ld/din/inr/s/r/conflict_clr, observes q/qbar/conflict.
//   slave  : register side.
// With SR_FLOP_REG_CARRY_EN defined the bundle also carries carry_out (register -> controller).
interface sr_flop_reg_if #(
  parameter int unsigned WIDTH = 16
);

  logic             en;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic             inr;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             conflict;
`ifdef SR_FLOP_REG_CARRY_EN
  logic             carry_out;
`endif

  modport master (
    output en, clr, ld, din, inr, s, r, conflict_clr,
`ifdef SR_FLOP_REG_CARRY_EN
    input  carry_out,
`endif
    input  q, qbar, conflict
  );

  modport slave (
    input  en, clr, ld, din, inr, s, r, conflict_clr,
`ifdef SR_FLOP_REG_CARRY_EN
    output carry_out,
`endif
    output q, qbar, conflict
  );

endinterface

// File: rtl/sr_flop_cell.sv
// Single-bit SR next-state function (purely combinational).
//   q_i      : current stored bit
//   s_i, r_i : set / reset request
//   q_next_o : next value; s=r=1 resolved by SR_POLICY (hold, set wins, reset wins, toggle)
module sr_flop_cell
  import sr_flop_pkg::*;
#(
  parameter int unsigned SR_POLICY = SR_HOLD
) (
  input  logic q_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case ({s_i, r_i})
      2'b10:   q_next_o = 1'b1;
      2'b01:   q_next_o = 1'b0;
      2'b11: begin
        case (SR_POLICY)
          SR_SET_WINS: q_next_o = 1'b1;
          SR_RST_WINS: q_next_o = 1'b0;
          SR_TOGGLE:   q_next_o = ~q_i;
          default:     q_next_o = q_i;
        endcase
      end
      default: q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/sr_flop_reg.sv
// Generic datapath register (AR/PC/DR/AC style) built from per-bit SR cells, with
// register-level clear, parallel load and increment layered on top.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, q <= RST_VAL, conflict <= 0
//   bus   : sr_flop_reg_if.slave (en, clr, ld, din, inr, s, r, conflict_clr -> q, qbar, conflict)
// Priority with en=1: clr > ld > inr > per-bit s/r. conflict is a sticky record of s=r=1 seen
// in s/r mode; conflict_clr clears it regardless of en, but a coincident new conflict wins.
// Optional macro SR_FLOP_REG_CARRY_EN adds carry_out: a one-cycle registered pulse after an
// increment from all-ones.
module sr_flop_reg
  import sr_flop_pkg::*;
#(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      RST_VAL   = '0,
  parameter int unsigned           SR_POLICY = SR_HOLD
) (
  input logic            clk,
  input logic            rst_n,
  sr_flop_reg_if.slave   bus
);

  if (SR_POLICY > SR_TOGGLE) begin : gen_bad_policy
    $error("sr_flop_reg: SR_POLICY must be 0..3");
  end

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  op_e              op;
  logic [WIDTH-1:0] q_d, q_q;
  logic             conflict_d, conflict_q;
  logic [WIDTH-1:0] sr_next;

  assign op = op_select(bus.en, bus.clr, bus.ld, bus.inr);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    sr_flop_cell #(
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .q_i      (q_q[i]),
      .s_i      (bus.s[i]),
      .r_i      (bus.r[i]),
      .q_next_o (sr_next[i])
    );
  end

  always_comb begin
    q_d = q_q;
    unique case (op)
      OP_CLR:  q_d = '0;
      OP_LD:   q_d = bus.din;
      OP_INR:  q_d = q_q + One;
      OP_SR:   q_d = sr_next;
      default: q_d = q_q;
    endcase
  end

  // Clear first so that a coincident new conflict overrides it.
  always_comb begin
    conflict_d = conflict_q;
    if (bus.conflict_clr) begin
      conflict_d = 1'b0;
    end
    if ((op == OP_SR) && (|(bus.s & bus.r))) begin
      conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= RST_VAL;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.qbar     = ~q_q;
  assign bus.conflict = conflict_q;

`ifdef SR_FLOP_REG_CARRY_EN
  logic carry_d, carry_q;

  assign carry_d = (op == OP_INR) && (&q_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign bus.carry_out = carry_q;
`endif

endmodule

// File: tb/tb_sr_flop_reg.sv
// Directed bench for sr_flop_reg: four instances, one per SR_POLICY, share all stimulus.
module tb_sr_flop_reg;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] RstVal = 16'hA5A5;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sr_flop_reg_if #(.WIDTH(W)) b0 ();
  sr_flop_reg_if #(.WIDTH(W)) b1 ();
  sr_flop_reg_if #(.WIDTH(W)) b2 ();
  sr_flop_reg_if #(.WIDTH(W)) b3 ();

  sr_flop_reg #(.WIDTH(W), .RST_VAL(RstVal), .SR_POLICY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  sr_flop_reg #(.WIDTH(W), .RST_VAL(RstVal), .SR_POLICY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  sr_flop_reg #(.WIDTH(W), .RST_VAL(RstVal), .SR_POLICY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  sr_flop_reg #(.WIDTH(W), .RST_VAL(RstVal), .SR_POLICY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic clr, input logic ld, input logic [W-1:0] din,
                       input logic inr, input logic [W-1:0] s, input logic [W-1:0] r,
                       input logic cclr);
    b0.en = en; b0.clr = clr; b0.ld = ld; b0.din = din; b0.inr = inr;
    b0.s = s; b0.r = r; b0.conflict_clr = cclr;
    b1.en = en; b1.clr = clr; b1.ld = ld; b1.din = din; b1.inr = inr;
    b1.s = s; b1.r = r; b1.conflict_clr = cclr;
    b2.en = en; b2.clr = clr; b2.ld = ld; b2.din = din; b2.inr = inr;
    b2.s = s; b2.r = r; b2.conflict_clr = cclr;
    b3.en = en; b3.clr = clr; b3.ld = ld; b3.din = din; b3.inr = inr;
    b3.s = s; b3.r = r; b3.conflict_clr = cclr;
  endtask

  // Apply the driven inputs on one rising edge, then leave the outputs settled for checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [W-1:0] v);
    drive(1'b1, 1'b0, 1'b1, v, 1'b0, '0, '0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    step(); step();
    vectors++;
    if (b0.q !== 16'hA5A5) begin
      miscompares++; $display("FAIL reset_q: got %h want a5a5", b0.q);
    end
    vectors++;
    if (b0.qbar !== 16'h5A5A) begin
      miscompares++; $display("FAIL reset_qbar: got %h want 5a5a", b0.qbar);
    end
    vectors++;
    if (b0.conflict !== 1'b0) begin
      miscompares++; $display("FAIL reset_conflict: got %b want 0", b0.conflict);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_all(16'h1234);
    vectors++;
    if (b0.q !== 16'h1234) begin
      miscompares++; $display("FAIL post_reset_load: got %h want 1234", b0.q);
    end
    // Reset asserted between edges must act at once.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b0.q !== 16'hA5A5 || b0.qbar !== 16'h5A5A || b0.conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got q=%h qbar=%h c=%b want a5a5 5a5a 0",
               b0.q, b0.qbar, b0.conflict);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    load_all(16'h0010);
    vectors++;
    if (b0.q !== 16'h0010) begin
      miscompares++; $display("FAIL prio_setup: got %h want 0010", b0.q);
    end
    drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h0000) begin
      miscompares++; $display("FAIL prio_clr: got %h want 0000", b0.q);
    end
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h1234) begin
      miscompares++; $display("FAIL prio_ld: got %h want 1234", b0.q);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h1235 || b0.qbar !== 16'hEDCA) begin
      miscompares++;
      $display("FAIL prio_inr: got q=%h qbar=%h want 1235 edca", b0.q, b0.qbar);
    end
`ifdef SR_FLOP_REG_CARRY_EN
    vectors++;
    if (b0.carry_out !== 1'b0) begin
      miscompares++; $display("FAIL carry_no_wrap: got %b want 0", b0.carry_out);
    end
`endif
  endtask

  task automatic test_wrap();
    load_all(16'hFFFF);
    vectors++;
    if (b0.q !== 16'hFFFF) begin
      miscompares++; $display("FAIL wrap_setup: got %h want ffff", b0.q);
    end
`ifdef SR_FLOP_REG_CARRY_EN
    vectors++;
    if (b0.carry_out !== 1'b0) begin
      miscompares++; $display("FAIL carry_on_ld: got %b want 0", b0.carry_out);
    end
`endif
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_inr: got %h want 0000", b0.q);
    end
`ifdef SR_FLOP_REG_CARRY_EN
    vectors++;
    if (b0.carry_out !== 1'b1) begin
      miscompares++; $display("FAIL carry_pulse: got %b want 1", b0.carry_out);
    end
`endif
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_hold: got %h want 0000", b0.q);
    end
`ifdef SR_FLOP_REG_CARRY_EN
    vectors++;
    if (b0.carry_out !== 1'b0) begin
      miscompares++; $display("FAIL carry_drop: got %b want 0", b0.carry_out);
    end
`endif
  endtask

  task automatic test_sr();
    load_all(16'h0000);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 16'h000F, 16'h0000, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h000F) begin
      miscompares++; $display("FAIL sr_set: got %h want 000f", b0.q);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 16'h0000, 16'h0003, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h000C) begin
      miscompares++; $display("FAIL sr_reset: got %h want 000c", b0.q);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h000C || b0.conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL sr_en_low: got q=%h c=%b want 000c 0", b0.q, b0.conflict);
    end
  endtask

  task automatic test_conflict();
    load_all(16'h00F0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 16'h0011, 16'h0011, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h00F0 || b0.conflict !== 1'b1) begin
      miscompares++; $display("FAIL pol_hold: got q=%h c=%b want 00f0 1", b0.q, b0.conflict);
    end
    vectors++;
    if (b1.q !== 16'h00F1 || b1.conflict !== 1'b1) begin
      miscompares++; $display("FAIL pol_set: got q=%h c=%b want 00f1 1", b1.q, b1.conflict);
    end
    vectors++;
    if (b2.q !== 16'h00E0 || b2.conflict !== 1'b1) begin
      miscompares++; $display("FAIL pol_rst: got q=%h c=%b want 00e0 1", b2.q, b2.conflict);
    end
    vectors++;
    if (b3.q !== 16'h00E1 || b3.conflict !== 1'b1) begin
      miscompares++; $display("FAIL pol_tgl: got q=%h c=%b want 00e1 1", b3.q, b3.conflict);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    step();
    vectors++;
    if (b0.conflict !== 1'b1) begin
      miscompares++; $display("FAIL conflict_sticky: got %b want 1", b0.conflict);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    step();
    vectors++;
    if ({b0.conflict, b1.conflict, b2.conflict, b3.conflict} !== 4'b0000) begin
      miscompares++;
      $display("FAIL conflict_clear: got %b%b%b%b want 0000",
               b0.conflict, b1.conflict, b2.conflict, b3.conflict);
    end
  endtask

  task automatic test_masked();
    drive(1'b1, 1'b0, 1'b1, 16'h0007, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    vectors++;
    if (b0.q !== 16'h0007 || b0.conflict !== 1'b0) begin
      miscompares++; $display("FAIL masked_ld: got q=%h c=%b want 0007 0", b0.q, b0.conflict);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 16'h0001, 16'h0001, 1'b1);
    step();
    vectors++;
    if (b0.q !== 16'h0007 || b0.conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_set: got q=%h c=%b want 0007 1", b0.q, b0.conflict);
    end
    // conflict_clr acts even with en low.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 16'h0001, 16'h0001, 1'b1);
    step();
    vectors++;
    if (b0.conflict !== 1'b0 || b0.q !== 16'h0007) begin
      miscompares++;
      $display("FAIL clr_en_low: got q=%h c=%b want 0007 0", b0.q, b0.conflict);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    test_reset();
    test_priority();
    test_wrap();
    test_sr();
    test_conflict();
    test_masked();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flop_reg.md
Name: sr_flop_reg

Overview:
- Parametrised clocked register built from per-bit SR flip-flop cells. Each bit has its own set and reset inputs.
- Register-level CLR / LD / INR operations are added on top, for use as the generic AR/PC/DR/AC-style register in the basic computer datapath.
- Replaces ad-hoc gated latches with edge-triggered storage.
- The forbidden S=R=1 condition resolves deterministically per a policy parameter and is flagged.

Parameters:
- WIDTH, 16, number of bits/cells.
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).
- SR_POLICY, 0, action on S=R=1 per bit: 0=hold, 1=set wins, 2=reset wins, 3=toggle (JK behaviour).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global clock enable; when 0 nothing changes except conflict_clr handling.
- clr  input  1  synchronous clear of q to 0.
- ld  input  1  synchronous parallel load of din.
- din  input  WIDTH  load data.
- inr  input  1  synchronous increment q+1, modulo 2^WIDTH.
- s  input  WIDTH  per-bit set.
- r  input  WIDTH  per-bit reset.
- conflict_clr  input  1  clears the sticky conflict flag.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always ~q, combinational from q, never registered separately.
- conflict  output  1  sticky flag: some bit saw s=r=1 while SR mode was active.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - q=RST_VAL, qbar=~RST_VAL, conflict=0.
  - Release is synchronous to the next rising edge; the first update occurs on the first edge with rst_n=1.
- Latency: one cycle. Inputs are sampled at the rising edge; q is valid after that edge.
- Priority when en=1, highest first: clr > ld > inr > per-bit s/r. Exactly one operation class applies per cycle.
  - clr=1: q<=0. ld, inr, s, r are ignored.
  - ld=1 (clr=0): q<=din.
  - inr=1 (clr=ld=0): q<=q+1. 2^WIDTH-1 wraps to 0 with no error.
  - SR mode (clr=ld=inr=0), per bit i:
    - s=0, r=0: hold.
    - s=1, r=0: set to 1.
    - s=0, r=1: reset to 0.
    - s=1, r=1: apply SR_POLICY.
- Conflict flag:
  - Set on an edge where SR mode is active, en=1, and |(s&r)=1. This applies even when SR_POLICY=3.
  - s=r=1 during clr/ld/inr cycles does not set the flag.
  - conflict_clr=1 clears the flag on the edge, regardless of en.
  - If conflict_clr and a new conflict coincide, set wins and conflict=1.
- en=0: q holds, s/r/clr/ld/inr are ignored, and no conflict is recorded.
- No combinational path from inputs to q/qbar. The only combinational logic is qbar=~q.
- Illegal SR_POLICY value (>3): elaboration error.

Optional Feature:
- Macro SR_FLOP_REG_CARRY_EN.
- Defined: adds output port carry_out (1 bit, reset 0).
  - Registered pulse, high for exactly one cycle after an edge where inr executed and q was all-ones.
  - Low in all other cycles, including ld/clr cycles.
- Undefined: port absent, no extra logic; all other behaviour identical.

Decomposition:
- Shared package sr_flop_pkg holds:
  - Policy constants SR_HOLD=0, SR_SET_WINS=1, SR_RST_WINS=2, SR_TOGGLE=3.
  - An op-select enum (OP_NONE, OP_CLR, OP_LD, OP_INR, OP_SR) reused by datapath control.
- One sub-module, sr_flop_cell: a single-bit next-state function with policy parameter taking q, s, r. It is generated WIDTH times and used only in OP_SR cycles.
- The priority mux and incrementer stay in the top level.

Test Plan:
- Reset: rst_n=0 mid-cycle with RST_VAL=16'hA5A5 -> q=A5A5, qbar=5A5A, conflict=0 immediately, without waiting for a clock edge.
- Priority: q=0010, set clr=ld=inr=1 with din=FFFF -> q=0000. Next cycle ld=inr=1, din=1234 -> q=1234. Next cycle inr=1 -> q=1235.
- Wrap: q=FFFF, inr=1 -> q=0000. With SR_FLOP_REG_CARRY_EN defined, carry_out=1 for one cycle, then 0.
- SR per bit: q=0000, s=000F, r=0000 -> q=000F. Then r=0003 -> q=000C. Then en=0 with s=FFFF -> q stays 000C.
- Conflict, one run per policy from q=00F0 with s=r=0011:
  - policy 0 -> q=00F0.
  - policy 1 -> q=00F1.
  - policy 2 -> q=00E0.
  - policy 3 -> q=00E1.
  - conflict=1 in every run. Then conflict_clr=1 with no conflict -> conflict=0.
- Masked conflict: ld=1, din=0007, s=r=FFFF -> q=0007, conflict remains 0. Next cycle conflict_clr=1 together with a new s=r=0001 conflict -> conflict=1.
